dptr_bank: RTL
==============

Name: dptr_bank

Overview:
- Parametrised data-pointer bank for the 8051 core: NUM_DPTR independent 16-bit pointers with one active at a time.
- Active pointer is chosen through a DPS select SFR; it is accessed through the DPL/DPH SFR addresses and drives the external-memory address path.
- Supports SFR read/write, 16-bit immediate load (MOV DPTR,#data16), INC DPTR with carry, and optional post-MOVX auto-step with auto-toggle of the active pointer.
- Sits on the SFR bus beside the other core SFRs and feeds the MOVX/MOVC address mux.

Parameters:
- NUM_DPTR, 2, number of pointers; legal values 1, 2, 4, 8.
- DPL_ADDR, 8'h82, SFR address of the active pointer low byte.
- DPH_ADDR, 8'h83, SFR address of the active pointer high byte.
- DPS_ADDR, 8'h86, SFR address of the select/control register.

Ports:
- clock  input  1  core clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- sfr_wr  input  1  SFR byte-write strobe
- sfr_wr_bit  input  1  bit-write qualifier; this block ignores any write with sfr_wr_bit=1
- sfr_addr  input  8  SFR address for read and write
- sfr_data_in  input  8  SFR write data
- sfr_data_out  output  8  SFR read data, combinational from sfr_addr
- sfr_hit  output  1  high when sfr_addr equals DPL_ADDR, DPH_ADDR or DPS_ADDR
- dptr_load  input  1  load the active pointer from load_value
- load_value  input  16  immediate value for dptr_load
- inc_dptr  input  1  INC DPTR: active pointer +1
- movx_done  input  1  one-cycle pulse when a MOVX @DPTR completes
- dptr_out  output  16  active pointer {DPH,DPL}, combinational from registers
- dps_out  output  8  current DPS register value

Behaviour:
- Reset (asynchronous): all pointers 16'h0000, DPS 8'h00.
  - Active pointer is therefore 0, so dptr_out=16'h0000, dps_out=8'h00 and sfr_data_out=8'h00.
- DPS layout:
  - [SEL_W-1:0] SEL selects the active pointer; SEL_W=max(1,clog2(NUM_DPTR)).
  - [7] AID: auto-step enable on movx_done.
  - [5] TSL: toggle the LSB of SEL after each auto-step.
  - [6] ID: see Optional Feature.
  - All other bits read 0; writes to them are ignored.
  - NUM_DPTR=1: SEL reads 0, SEL writes ignored, TSL has no effect.
- SFR write, accepted when sfr_wr=1 and sfr_wr_bit=0:
  - DPL_ADDR writes active pointer [7:0]; DPH_ADDR writes active pointer [15:8]. The other byte is unchanged.
  - DPS_ADDR writes DPS.
  - Write takes effect at the same edge; new value is visible the next cycle.
- SFR read: sfr_data_out returns the active DPL, active DPH or DPS for a matching address, else 8'h00. No side effects.
- Active pointer update, one action per cycle, in this priority:
  1. dptr_load
  2. SFR write to DPL or DPH
  3. inc_dptr
  4. movx_done with AID=1
  - The lower-priority action in that cycle is dropped, not deferred.
- Arithmetic: 16-bit modulo.
  - 16'hFFFF+1 = 16'h0000.
  - 16'h00FF+1 = 16'h0100 (carry into DPH in the same cycle).
- inc_dptr and movx_done together: pointer steps by exactly 1; TSL toggle does not occur.
- Auto-step, when movx_done=1, AID=1 and no higher-priority action:
  - Active pointer steps by 1.
  - Then, if TSL=1 and NUM_DPTR>1, SEL[0] inverts at the same edge.
  - From the next cycle dptr_out reflects the newly selected pointer.
- DPS write vs. auto-step toggle in the same cycle: the DPS write wins and the toggle is dropped. The pointer step still occurs.
- A SEL change redirects dptr_out and DPL/DPH accesses the next cycle. Inactive pointers keep their values.
- Reset asserted mid-operation clears everything immediately. No pending actions are kept.

Optional Feature:
- Macro: DPTR_DEC_EN.
- Defined:
  - DPS[6] (ID) is writable.
  - When ID=1, auto-step on movx_done decrements: 16'h0000-1 = 16'hFFFF.
  - inc_dptr always increments.
- Undefined:
  - DPS[6] reads 0 and writes are ignored.
  - Auto-step always increments.

Test Plan:
- Reset, then write DPL=8'h34, DPH=8'h12 -> dptr_out=16'h1234, sfr_data_out at DPH_ADDR=8'h12, sfr_hit=1; sfr_addr=8'h80 -> sfr_hit=0, data 8'h00.
- Load pointer 0 with 16'h00FF, inc_dptr -> 16'h0100; load 16'hFFFF, inc_dptr -> 16'h0000.
- DPS=8'h01, load 16'hABCD, then DPS=8'h00 -> dptr_out returns the pointer 0 value, pointer 1 retains 16'hABCD; sfr_wr_bit=1 write to DPL -> no change.
- DPS=8'hA0, pointer0=16'h1000, pointer1=16'h2000, movx_done pulse -> pointer0=16'h1001, SEL=1, dptr_out=16'h2000; second pulse -> pointer1=16'h2001, SEL=0.
- Same cycle dptr_load(16'h5555)+inc_dptr+movx_done -> pointer=16'h5555, SEL unchanged; assert reset mid-sequence -> all zero asynchronously.
- With DPTR_DEC_EN, DPS=8'hC0, pointer=16'h0000, movx_done -> 16'hFFFF; without the macro, DPS write 8'hC0 reads back 8'h80 and the same pulse yields 16'h0001.

Source files
------------

// File: rtl/dptr_bank.sv
// Data-pointer bank for the 8051 core: NUM_DPTR 16-bit pointers, one active, selected by DPS.
// Optional macro DPTR_DEC_EN makes DPS[6] (ID) writable so MOVX auto-step can decrement.
module dptr_bank #(
    parameter int          NUM_DPTR = 2,
    parameter logic [7:0]  DPL_ADDR = 8'h82,
    parameter logic [7:0]  DPH_ADDR = 8'h83,
    parameter logic [7:0]  DPS_ADDR = 8'h86
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sfr_wr,
    input  logic        sfr_wr_bit,
    input  logic [7:0]  sfr_addr,
    input  logic [7:0]  sfr_data_in,
    output logic [7:0]  sfr_data_out,
    output logic        sfr_hit,
    input  logic        dptr_load,
    input  logic [15:0] load_value,
    input  logic        inc_dptr,
    input  logic        movx_done,
    output logic [15:0] dptr_out,
    output logic [7:0]  dps_out
);

    localparam int         SEL_W    = (NUM_DPTR > 1) ? $clog2(NUM_DPTR) : 1;
    localparam logic [7:0] SEL_MASK = (NUM_DPTR > 1) ? 8'((1 << SEL_W) - 1) : 8'h00;
`ifdef DPTR_DEC_EN
    localparam logic [7:0] ID_MASK  = 8'h40;
`else
    localparam logic [7:0] ID_MASK  = 8'h00;
`endif
    // Writable DPS bits: AID, TSL, optional ID, and the SEL field.
    localparam logic [7:0] DPS_MASK = 8'hA0 | ID_MASK | SEL_MASK;

    logic [15:0]      ptr_q [NUM_DPTR];
    logic [15:0]      ptr_d [NUM_DPTR];
    logic [7:0]       dps_q;
    logic [7:0]       dps_d;
    logic [SEL_W-1:0] sel;
    logic [15:0]      active;
    logic [15:0]      active_d;
    logic             auto_step;
    logic             step_dec;
    logic             wr_ok;
    logic             wr_dpl;
    logic             wr_dph;
    logic             wr_dps;

    assign sel      = dps_q[SEL_W-1:0];
    assign wr_ok    = sfr_wr & ~sfr_wr_bit;
    assign wr_dpl   = wr_ok & (sfr_addr == DPL_ADDR);
    assign wr_dph   = wr_ok & (sfr_addr == DPH_ADDR);
    assign wr_dps   = wr_ok & (sfr_addr == DPS_ADDR);

`ifdef DPTR_DEC_EN
    assign step_dec = dps_q[6];
`else
    assign step_dec = 1'b0;
`endif

    always_comb begin
        active = 16'h0000;
        for (int i = 0; i < NUM_DPTR; i++) begin
            if (sel == SEL_W'(i)) begin
                active = ptr_q[i];
            end
        end
    end

    // One pointer action per cycle; lower-priority requests are dropped.
    always_comb begin
        active_d  = active;
        auto_step = 1'b0;
        if (dptr_load) begin
            active_d = load_value;
        end else if (wr_dpl) begin
            active_d = {active[15:8], sfr_data_in};
        end else if (wr_dph) begin
            active_d = {sfr_data_in, active[7:0]};
        end else if (inc_dptr) begin
            active_d = active + 16'd1;
        end else if (movx_done && dps_q[7]) begin
            auto_step = 1'b1;
            active_d  = step_dec ? (active - 16'd1) : (active + 16'd1);
        end
    end

    // A DPS write overrides the TSL toggle; with one pointer SEL_MASK[0] is 0 so no toggle.
    always_comb begin
        dps_d = dps_q;
        if (wr_dps) begin
            dps_d = sfr_data_in & DPS_MASK;
        end else if (auto_step && dps_q[5]) begin
            dps_d = dps_q ^ {7'b0, SEL_MASK[0]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DPTR; gi++) begin : g_ptr
            localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);
            assign ptr_d[gi] = (sel == IDX) ? active_d : ptr_q[gi];
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    ptr_q[gi] <= 16'h0000;
                end else begin
                    ptr_q[gi] <= ptr_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dps_q <= 8'h00;
        end else begin
            dps_q <= dps_d;
        end
    end

    always_comb begin
        sfr_data_out = 8'h00;
        sfr_hit      = 1'b0;
        if (sfr_addr == DPL_ADDR) begin
            sfr_data_out = active[7:0];
            sfr_hit      = 1'b1;
        end else if (sfr_addr == DPH_ADDR) begin
            sfr_data_out = active[15:8];
            sfr_hit      = 1'b1;
        end else if (sfr_addr == DPS_ADDR) begin
            sfr_data_out = dps_q;
            sfr_hit      = 1'b1;
        end
    end

    assign dptr_out = active;
    assign dps_out  = dps_q;

endmodule
